// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash ROM-port reader.
package spi_flash_reader_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    HOLD,
    CSGAP
  } state_e;

  function automatic logic [23:0] flash_addr(input logic [23:0] base, input logic [16:0] a);
    return base | {7'b0, a};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCK generation, MSB-first shift-out of up to 32 bits and 8-bit capture.
module spi_bit_engine #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_last_bit,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_done,
  output logic [7:0]  o_rx
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic            r_active;
  logic            r_sck;
  logic [DivW-1:0] r_div;
  logic [4:0]      r_bit;
  logic [31:0]     r_shift;
  logic [7:0]      r_rx;
  logic            w_half_end;

  assign w_half_end = r_active && (r_div == DivLast);
  // Done fires on the falling SCK edge that closes the last bit, so a new load can follow at once.
  assign o_done     = w_half_end && r_sck && (r_bit == 5'd0);
  assign o_sck      = r_sck;
  assign o_mosi     = r_shift[31];
  assign o_rx       = r_rx;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_rx     <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sck    <= 1'b0;
      r_div    <= '0;
      r_bit    <= i_last_bit;
      r_shift  <= i_data;
    end else if (w_half_end) begin
      r_div <= '0;
      if (!r_sck) begin
        r_sck <= 1'b1;
        r_rx  <= {r_rx[6:0], i_miso};
      end else begin
        r_sck   <= 1'b0;
        r_shift <= {r_shift[30:0], 1'b0};
        if (r_bit == 5'd0) begin
          r_active <= 1'b0;
        end else begin
          r_bit <= r_bit - 5'd1;
        end
      end
    end else if (r_active) begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// ROM-port byte server fetching from SPI flash with READ (0x03); sequential reads stream
// without re-sending command/address while CS is held low.
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter logic [23:0] BASE_ADDR   = 24'h100000,
  parameter int unsigned CS_HIGH_CYC = 4,
  parameter int unsigned HOLD_MAX    = 255
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        rom_rden,
  input  logic [16:0] rom_address,
  output logic [7:0]  rom_data,
  output logic        rom_data_ready,
  output logic        busy,
  output logic        flash_cs_n,
  output logic        flash_sck,
  input  logic        flash_miso,
  output logic        flash_mosi
);

  localparam logic [15:0] CsLast   = 16'(CS_HIGH_CYC - 1);
  localparam logic [15:0] HoldLast = 16'(HOLD_MAX - 1);
  localparam bit          HoldEn   = (HOLD_MAX != 0);

  state_e      r_state;
  logic        r_cs_n;
  logic        r_busy;
  logic        r_ready;
  logic [7:0]  r_data;
  logic [16:0] r_addr;
  logic [16:0] r_next_addr;
  logic        r_pending;
  logic [15:0] r_cs_cnt;
  logic [15:0] r_idle_cnt;

  logic        w_accept;
  logic        w_gap_ok;
  logic        w_seq_hit;
  logic        w_go_cmd;
  logic [16:0] w_req_addr;
  logic        w_start;
  logic [31:0] w_load;
  logic [4:0]  w_last_bit;
  logic        w_done;
  logic [7:0]  w_rx;

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_data     (w_load),
    .i_last_bit (w_last_bit),
    .i_miso     (flash_miso),
    .o_sck      (flash_sck),
    .o_mosi     (flash_mosi),
    .o_done     (w_done),
    .o_rx       (w_rx)
  );

  assign rom_data       = r_data;
  assign rom_data_ready = r_ready;
  assign busy           = r_busy;
  assign flash_cs_n     = r_cs_n;

  always_comb begin
    w_accept   = rom_rden && !r_busy;
    w_req_addr = r_pending ? r_addr : rom_address;
    w_gap_ok   = (r_cs_cnt == CsLast);
    // Address 0 after 17'h1FFFF is not a continuation: the flash would read BASE+0x20000.
    w_seq_hit  = w_accept && (rom_address == r_next_addr) && (r_next_addr != 17'd0);
    w_go_cmd   = ((r_state == IDLE) || (r_state == CSGAP)) && (r_pending || w_accept) && w_gap_ok;
    w_start    = 1'b0;
    w_load     = '0;
    w_last_bit = 5'd7;
    if (w_go_cmd) begin
      w_start = 1'b1;
      w_load  = {SPI_CMD_READ, 24'h0};
    end else if ((r_state == HOLD) && w_seq_hit) begin
      w_start = 1'b1;
    end else if (w_done && (r_state == CMD)) begin
      w_start    = 1'b1;
      w_load     = {flash_addr(BASE_ADDR, r_addr), 8'h0};
      w_last_bit = 5'd23;
    end else if (w_done && (r_state == ADDR)) begin
      w_start = 1'b1;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_pending   <= 1'b0;
      r_cs_cnt    <= CsLast;
      r_idle_cnt  <= '0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        IDLE, CSGAP: begin
          if (w_go_cmd) begin
            r_state   <= CMD;
            r_cs_n    <= 1'b0;
            r_addr    <= w_req_addr;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            if (!w_gap_ok) r_cs_cnt <= r_cs_cnt + 16'd1;
            if (w_accept) begin
              r_addr    <= rom_address;
              r_pending <= 1'b1;
              r_busy    <= 1'b1;
            end
            if ((r_state == CSGAP) && w_gap_ok) r_state <= IDLE;
          end
        end
        CMD: if (w_done) r_state <= ADDR;
        ADDR: if (w_done) r_state <= DATA;
        DATA: begin
          if (w_done) begin
            r_state     <= HOLD;
            r_data      <= w_rx;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_next_addr <= r_addr + 17'd1;
            r_idle_cnt  <= '0;
          end
        end
        HOLD: begin
          if (w_seq_hit) begin
            r_state <= DATA;
            r_addr  <= rom_address;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_state   <= CSGAP;
            r_cs_n    <= 1'b1;
            r_cs_cnt  <= '0;
            r_addr    <= rom_address;
            r_pending <= 1'b1;
            r_busy    <= 1'b1;
          end else if (HoldEn && (r_idle_cnt == HoldLast)) begin
            r_state  <= CSGAP;
            r_cs_n   <= 1'b1;
            r_cs_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: behavioural SPI flash plus a transaction-level
// latency/data model, directed scenarios followed by randomized reads.
module tb_spi_flash_reader;

  localparam logic [23:0] BASE = 24'h100000;

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_rden = 1'b0;
  logic [16:0] rom_address = 17'd0;
  logic [7:0]  rom_data;
  logic        rom_data_ready;
  logic        busy;
  logic        flash_cs_n;
  logic        flash_sck;
  logic        flash_miso;
  logic        flash_mosi;

  spi_flash_reader dut (
    .clk28          (clk28),
    .rst_n          (rst_n),
    .rom_rden       (rom_rden),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .rom_data_ready (rom_data_ready),
    .busy           (busy),
    .flash_cs_n     (flash_cs_n),
    .flash_sck      (flash_sck),
    .flash_miso     (flash_miso),
    .flash_mosi     (flash_mosi)
  );

  always #5 clk28 = ~clk28;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [7:0]  seed = 8'h00;

  // Flash contents: fixed pseudo-random pattern, with the one byte the first read expects.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h100010) return 8'hA5;
    return (a[7:0] * 8'd37) ^ a[15:8] ^ {a[23:17], a[16]} ^ seed;
  endfunction

  // Behavioural flash: collects 32 command/address bits, then streams bytes on falling SCK.
  int unsigned sessions = 0;
  logic [31:0] last_cmd = 32'h0;
  int unsigned m_bits = 0;
  logic [31:0] m_word = 32'h0;
  logic [23:0] m_addr = 24'h0;
  logic [2:0]  m_bit = 3'd0;
  logic [7:0]  m_byte;
  logic        p_sck = 1'b0;

  always @(flash_sck or flash_cs_n) begin
    if (flash_cs_n) begin
      m_bits     = 0;
      m_bit      = 3'd0;
      flash_miso = 1'b0;
    end else if (flash_sck && !p_sck) begin
      if (m_bits < 32) begin
        m_word = {m_word[30:0], flash_mosi};
        m_bits = m_bits + 1;
        if (m_bits == 32) begin
          sessions = sessions + 1;
          last_cmd = m_word;
          m_addr   = m_word[23:0];
          m_bit    = 3'd0;
        end
      end
    end else if (!flash_sck && p_sck && (m_bits == 32)) begin
      m_byte     = flash_byte(m_addr);
      flash_miso = m_byte[3'd7 - m_bit];
      m_bit      = m_bit + 3'd1;
      if (m_bit == 3'd0) m_addr = m_addr + 24'd1;
    end
    p_sck = flash_sck;
  end

  int unsigned cyc = 0;
  int unsigned rdy_cnt = 0;
  int unsigned hi_run = 0;
  int unsigned last_hi = 0;

  always @(posedge clk28) cyc <= cyc + 1;
  always @(negedge clk28) if (rom_data_ready) rdy_cnt <= rdy_cnt + 1;
  always @(negedge clk28) begin
    if (flash_cs_n) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0) last_hi <= hi_run;
      hi_run <= 0;
    end
  end

  // Transaction-level view: is a CS-low session open, and which address would continue it.
  bit          m_open = 1'b0;
  logic [16:0] m_next = 17'd0;
  int unsigned m_rdy_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk28);
      #1;
    end
  endtask

  task automatic xfer(input logic [16:0] a, input string tag);
    int unsigned exp_lat;
    bit          exp_new;
    int unsigned lat;
    int unsigned s0;
    logic [23:0] fa;
    fa = BASE | {7'b0, a};
    if (m_open && ((cyc - m_rdy_cyc) > 254)) m_open = 1'b0;
    if (m_open && (a == m_next) && (m_next != 17'd0)) begin
      exp_lat = 33;
      exp_new = 1'b0;
    end else if (m_open) begin
      exp_lat = 165;
      exp_new = 1'b1;
    end else begin
      exp_lat = 161;
      exp_new = 1'b1;
    end
    s0 = sessions;
    rom_rden    = 1'b1;
    rom_address = a;
    lat         = 0;
    do begin
      tick(1);
      lat++;
      rom_rden = 1'b0;
    end while (!rom_data_ready && (lat < 400));
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, {24'h0, rom_data}, {24'h0, flash_byte(fa)});
    check({tag, " busy"}, {31'h0, busy}, 32'h0);
    if (exp_new) begin
      check({tag, " sessions"}, sessions, s0 + 1);
      check({tag, " cmd"}, last_cmd, {8'h03, fa});
    end else begin
      check({tag, " no reissue"}, sessions, s0);
    end
    m_open    = 1'b1;
    m_next    = a + 17'd1;
    m_rdy_cyc = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int unsigned r0;
    int unsigned s0;
    int unsigned g;
    logic [16:0] a;

    seed = 8'($urandom);
    tick(3);
    check("reset cs_n", {31'h0, flash_cs_n}, 32'h1);
    check("reset sck", {31'h0, flash_sck}, 32'h0);
    check("reset mosi", {31'h0, flash_mosi}, 32'h0);
    check("reset data", {24'h0, rom_data}, 32'h0);
    check("reset ready", {31'h0, rom_data_ready}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    tick(4);
    check("idle cs_n", {31'h0, flash_cs_n}, 32'h1);
    check("idle no ready", rdy_cnt, 32'h0);

    xfer(17'h00010, "first");
    check("first A5", {24'h0, rom_data}, 32'hA5);
    xfer(17'h00011, "stream1");
    xfer(17'h00012, "stream2");
    xfer(17'h00013, "stream3");

    xfer(17'h00200, "nonseq");
    check("nonseq cs gap", last_hi, 32'd4);

    tick(254);
    check("hold cs low", {31'h0, flash_cs_n}, 32'h0);
    tick(1);
    check("timeout cs high", {31'h0, flash_cs_n}, 32'h1);
    tick(10);
    xfer(17'h00201, "after timeout");

    tick(300);
    xfer(17'h1FFFF, "top");
    xfer(17'h00000, "wrap");

    tick(300);
    r0 = rdy_cnt;
    s0 = sessions;
    c0 = cyc;
    rom_rden    = 1'b1;
    rom_address = 17'h00ABC;
    tick(1);
    rom_rden = 1'b0;
    tick(49);
    check("busy in addr", {31'h0, busy}, 32'h1);
    rom_rden    = 1'b1;
    rom_address = 17'h01234;
    tick(1);
    rom_rden = 1'b0;
    while (!rom_data_ready && ((cyc - c0) < 400)) tick(1);
    check("busy-ignore latency", cyc - c0, 32'd161);
    check("busy-ignore data", {24'h0, rom_data}, {24'h0, flash_byte(BASE | 24'h000ABC)});
    check("busy-ignore cmd", last_cmd, {8'h03, BASE | 24'h000ABC});
    check("busy-ignore sessions", sessions, s0 + 1);
    m_open    = 1'b1;
    m_next    = 17'h00ABD;
    m_rdy_cyc = cyc;
    tick(200);
    check("busy-ignore one ready", rdy_cnt, r0 + 1);

    tick(100);
    c0 = cyc;
    rom_rden    = 1'b1;
    rom_address = 17'h00777;
    tick(1);
    rom_rden = 1'b0;
    tick(139);
    r0 = rdy_cnt;
    rst_n = 1'b0;
    #1;
    check("midreset cs_n", {31'h0, flash_cs_n}, 32'h1);
    check("midreset sck", {31'h0, flash_sck}, 32'h0);
    check("midreset busy", {31'h0, busy}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    m_open = 1'b0;
    tick(100);
    check("midreset no ready", rdy_cnt, r0);
    xfer(17'h00777, "after reset");

    for (int i = 0; i < 12; i++) begin
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(300, 320) : $urandom_range(0, 30);
      tick(int'(g));
      a = ($urandom_range(0, 2) != 0) ? m_next : 17'($urandom);
      xfer(a, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Upstream ROM-port server for rom2ram. It accepts byte read requests on the rom_* handshake and fetches each byte from the board SPI flash using READ (0x03) in SPI mode 0.
- It returns the byte with a one-cycle ready strobe.
- Consecutive-address requests are streamed without reissuing command or address. This makes the boot-time ROM→RAM copy run at close to 8 SCK bits per byte.

Parameters:
- CLK_DIV, 2: SCK half-period in clk28 cycles (≥1). One bit time = 2*CLK_DIV cycles.
- BASE_ADDR, 24'h100000: flash byte offset added to rom_address. Must be aligned to 128 KiB.
- CS_HIGH_CYC, 4: minimum clk28 cycles flash_cs_n stays high between transactions (≥1).
- HOLD_MAX, 255: idle cycles in HOLD before CS is released. 0 disables the timeout.

Ports:
- clk28  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rom_rden  in  1  one-cycle read request
- rom_address  in  17  byte address, sampled when rom_rden=1 and busy=0
- rom_data  out  8  fetched byte; feeds rom2ram datain
- rom_data_ready  out  1  one-cycle strobe, rom_data valid
- busy  out  1  request in progress; rom_rden ignored while 1
- flash_cs_n  out  1  flash chip select
- flash_sck  out  1  flash clock, idle low
- flash_miso  in  1  flash serial data out
- flash_mosi  out  1  flash serial data in

Behaviour:
- Reset (async assert, sync release):
  - flash_cs_n=1, flash_sck=0, flash_mosi=0.
  - rom_data=0, rom_data_ready=0, busy=0.
  - State=IDLE, CS-high counter preloaded as already satisfied.
- Reset mid-transfer: CS goes high immediately, the transfer is abandoned, and no ready strobe is issued.
- Flash address = BASE_ADDR | {7'b0, rom_address}. The next expected address is held as a 17-bit register.
- SPI mode 0:
  - MOSI changes while SCK is low; MISO is sampled on the clk28 edge where SCK rises.
  - Bits are shifted MSB first.
  - Each bit spans one low half and one high half, each CLK_DIV cycles long.
- States:
  - IDLE: CS high. On a request with the CS-high counter satisfied, latch the address, set busy=1, go to CMD.
    - If the counter is not yet satisfied, the request is latched and busy=1 asserts at once; CMD starts once the counter expires.
  - CMD: shift 8'h03, then go to ADDR.
  - ADDR: shift the 24-bit flash address, then go to DATA.
  - DATA: shift 8 bits in from MISO; MOSI=0. After the 8th rising-edge sample:
    - drive SCK low;
    - load rom_data;
    - pulse rom_data_ready for one cycle;
    - clear busy in the same cycle;
    - set next_addr = latched+1 (17-bit wrap);
    - go to HOLD.
  - HOLD: CS low, SCK low, idle counter runs.
    - Request with rom_address==next_addr and next_addr≠0 → DATA directly, busy=1.
    - Request with any other address, including a wrap from 17'h1FFFF to 0 → go to CSGAP with the request latched, busy=1.
    - Idle counter reaches HOLD_MAX (if nonzero) → go to CSGAP with no request pending.
  - CSGAP: CS high for CS_HIGH_CYC cycles.
    - Request pending → CMD.
    - No request pending → IDLE.
    - A request arriving here (busy=0) is latched and busy asserts.
- Latency, from the rom_rden cycle to the rom_data_ready cycle:
  - From IDLE: 1 + 40*2*CLK_DIV cycles.
  - Streamed from HOLD: 1 + 8*2*CLK_DIV cycles.
  - From HOLD with a non-sequential address: add CS_HIGH_CYC to the IDLE figure.
- rom_data is stable from the ready strobe until the next ready strobe.
- rom_rden asserted while busy=1 is ignored: no queueing and no error.
- rom_rden in the same cycle as rom_data_ready is accepted, because busy=0 in that cycle.

Decomposition:
- Shared package: SPI_CMD_READ=8'h03; state enum {IDLE, CMD, ADDR, DATA, HOLD, CSGAP}.
- Sub-module: spi_bit_engine. It generates SCK from CLK_DIV and provides a load/shift register of up to 32 bits with a done pulse.
- The top level holds the FSM, the address compare and the counters.

Test Plan:
- Reset with CLK_DIV=2: before any request, CS=1, SCK=0 and no ready strobe. A request at 17'h00010 → MOSI carries 03 10 00 10, 32 rising edges, then 8 data edges. Flash model returns 0xA5 → rom_data=0xA5 with ready exactly 161 cycles after rden.
- Sequential stream at 0x00010..0x00013, each request issued in its ready cycle → CS stays low, no command is reissued, each ready arrives 33 cycles after its rden, data matches the model.
- Non-sequential: after 0x00010, request 0x00200 → CS high for exactly 4 cycles, then full 03 10 02 00 sequence, ready 165 cycles after rden.
- Wrap: after 17'h1FFFF, request 0 → treated as a new transaction; flash address on MOSI is 10 00 00.
- Timeout with HOLD_MAX=255: idle 255 cycles in HOLD → CS rises. The next request at next_addr → full command issued.
- Busy and reset: a second rden during ADDR is ignored (no extra ready, sampled address unchanged). rst_n low mid-DATA → CS=1 in the same cycle, no ready. After release, a fresh read completes normally.
